// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: shared state encodings, forward select codes and shadow-entry type
// for the ID-stage hazard detection and forwarding unit.
package hazard_forward_unit_pkg;
    localparam int CTRL_W = 22;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, FREEZE = 2'd2} state_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       rf_en;
        logic       load;
    } shadow_t;
    function automatic logic is_writer(input shadow_t e);
        return e.valid && e.rf_en && (e.dest != 5'd0);
    endfunction
endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: priority compare for one source operand against the EX, MEM and WB writers;
// the youngest matching writer wins.
module fwd_select import hazard_forward_unit_pkg::*; (
    input  logic       i_use,
    input  logic [4:0] i_src,
    input  logic       i_ex_wr,
    input  logic [4:0] i_ex_dest,
    input  logic       i_mem_wr,
    input  logic [4:0] i_mem_dest,
    input  logic       i_wb_wr,
    input  logic [4:0] i_wb_dest,
    output logic [1:0] o_sel
);
    logic w_live;
    assign w_live = i_use && (i_src != 5'd0);
    always_comb
        o_sel = !w_live                              ? FWD_RF  :
                (i_ex_wr  && i_ex_dest  == i_src)    ? FWD_EX  :
                (i_mem_wr && i_mem_dest == i_src)    ? FWD_MEM :
                (i_wb_wr  && i_wb_dest  == i_src)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks EX/MEM/WB destinations in a shadow pipeline, drives operand
// forwarding, inserts one bubble per load-use hazard and freezes everything on mem_busy.
module hazard_forward_unit import hazard_forward_unit_pkg::*; #(
    parameter int CTRL_W = hazard_forward_unit_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [4:0]        id_dest,
    input  logic              id_rf_enable,
    input  logic              id_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              mem_busy,
    output logic              pc_le,
    output logic              ifid_le,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);
    state_t           r_state, w_next;
    shadow_t          r_ex, r_mem, r_wb, w_id;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ex_wr, w_mem_wr, w_wb_wr, w_load_use, w_bubble, w_adv;
    logic [1:0]       w_fwd_a, w_fwd_b;
    logic             w_unused;

    assign w_id       = '{valid: 1'b1, dest: id_dest, rf_en: id_rf_enable, load: id_load};
    assign w_ex_wr    = is_writer(r_ex);
    assign w_mem_wr   = is_writer(r_mem);
    assign w_wb_wr    = is_writer(r_wb);
    assign w_unused   = ^{r_mem.load, r_wb.load};
    assign w_load_use = w_ex_wr && r_ex.load &&
                        ((id_use_rs && r_ex.dest == id_rs) || (id_use_rt && r_ex.dest == id_rt));
    // The bubble cycle leaves EX invalid, so a load can never cause two bubbles in a row.
    assign w_adv      = !reset && !mem_busy;
    assign w_bubble   = w_adv && w_load_use && r_state != BUBBLE;

    fwd_select u_fwd_a (
        .i_use(id_use_rs), .i_src(id_rs),
        .i_ex_wr(w_ex_wr), .i_ex_dest(r_ex.dest),
        .i_mem_wr(w_mem_wr), .i_mem_dest(r_mem.dest),
        .i_wb_wr(w_wb_wr), .i_wb_dest(r_wb.dest),
        .o_sel(w_fwd_a)
    );
    fwd_select u_fwd_b (
        .i_use(id_use_rt), .i_src(id_rt),
        .i_ex_wr(w_ex_wr), .i_ex_dest(r_ex.dest),
        .i_mem_wr(w_mem_wr), .i_mem_dest(r_mem.dest),
        .i_wb_wr(w_wb_wr), .i_wb_dest(r_wb.dest),
        .o_sel(w_fwd_b)
    );

    always_comb begin
        w_next  = mem_busy ? FREEZE : w_bubble ? BUBBLE : RUN;
        pc_le   = w_adv && !w_bubble;
        ifid_le = pc_le;
        ex_ctrl = pc_le ? id_ctrl : '0;
        fwd_a   = reset ? FWD_RF : w_fwd_a;
        fwd_b   = reset ? FWD_RF : w_fwd_b;
    end

    assign stall_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (!mem_busy) begin
                r_ex  <= w_bubble ? '0 : w_id;
                r_mem <= r_ex;
                r_wb  <= r_mem;
            end
            if (w_bubble && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: table of per-cycle stimulus with hand-computed outputs, plus a
// repeated load-use sequence checking counter saturation on a narrow-counter instance.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        id_rs, id_rt, id_dest;
    logic              id_use_rs, id_use_rt, id_rf_enable, id_load, mem_busy;
    logic [CTRL_W-1:0] id_ctrl, ex_ctrl, s_ex_ctrl;
    logic              pc_le, ifid_le, s_pc_le, s_ifid_le;
    logic [1:0]        fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic [15:0]       stall_cnt;
    logic [1:0]        s_cnt;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    hazard_forward_unit u_dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
        .id_rf_enable(id_rf_enable), .id_load(id_load), .id_ctrl(id_ctrl),
        .mem_busy(mem_busy), .pc_le(pc_le), .ifid_le(ifid_le), .ex_ctrl(ex_ctrl),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    // Two-bit counter so saturation is reachable in a handful of hazards.
    hazard_forward_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
        .id_rf_enable(id_rf_enable), .id_load(id_load), .id_ctrl(id_ctrl),
        .mem_busy(mem_busy), .pc_le(s_pc_le), .ifid_le(s_ifid_le), .ex_ctrl(s_ex_ctrl),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_cnt)
    );

    typedef struct {
        int rst, busy, rs, rt, urs, urt, dst, wen, ld;
        int e_pc, e_fa, e_fb, e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int rst, busy, rs, rt, urs, urt, dst, wen, ld, ctrl);
        reset        = rst[0];
        mem_busy     = busy[0];
        id_rs        = rs[4:0];
        id_rt        = rt[4:0];
        id_use_rs    = urs[0];
        id_use_rt    = urt[0];
        id_dest      = dst[4:0];
        id_rf_enable = wen[0];
        id_load      = ld[0];
        id_ctrl      = CTRL_W'(ctrl);
    endtask

    vec_t v[24];

    initial begin
        //        rst busy rs rt urs urt dst wen ld  pc fa fb cnt
        v[0]  = '{1, 0,  8, 0, 1, 0,  8, 1, 1,  0, 0, 0, 0};
        v[1]  = '{0, 0,  1, 0, 1, 0,  8, 1, 1,  1, 0, 0, 0};
        v[2]  = '{0, 0,  8, 3, 1, 1,  9, 1, 0,  0, 1, 0, 0};
        v[3]  = '{0, 0,  8, 3, 1, 1,  9, 1, 0,  1, 2, 0, 1};
        v[4]  = '{0, 0,  9, 8, 1, 1,  5, 1, 0,  1, 1, 3, 1};
        v[5]  = '{0, 0,  9, 5, 1, 1,  5, 1, 0,  1, 2, 1, 1};
        v[6]  = '{0, 0,  9, 5, 1, 1,  5, 1, 0,  1, 3, 1, 1};
        v[7]  = '{0, 0,  9, 5, 1, 1,  0, 1, 1,  1, 0, 1, 1};
        v[8]  = '{0, 0,  0, 5, 1, 0,  7, 0, 0,  1, 0, 0, 1};
        v[9]  = '{0, 0,  0, 5, 0, 1,  6, 1, 0,  1, 0, 3, 1};
        v[10] = '{0, 0,  6, 2, 1, 0,  4, 1, 1,  1, 1, 0, 1};
        v[11] = '{0, 1,  6, 4, 1, 1, 10, 1, 0,  0, 2, 1, 1};
        v[12] = '{0, 1,  6, 4, 1, 1, 10, 1, 0,  0, 2, 1, 1};
        v[13] = '{0, 1,  6, 4, 1, 1, 10, 1, 0,  0, 2, 1, 1};
        v[14] = '{0, 0,  6, 4, 1, 1, 10, 1, 0,  0, 2, 1, 1};
        v[15] = '{0, 0,  6, 4, 1, 1, 10, 1, 0,  1, 3, 2, 2};
        v[16] = '{0, 0, 10, 4, 1, 1, 12, 1, 1,  1, 1, 3, 2};
        v[17] = '{0, 0, 12,10, 1, 1, 13, 1, 0,  0, 1, 2, 2};
        v[18] = '{1, 0, 12,10, 1, 1, 13, 1, 0,  0, 0, 0, 3};
        v[19] = '{0, 0, 12,10, 1, 1, 13, 1, 0,  1, 0, 0, 0};
        v[20] = '{0, 0, 13, 0, 1, 0, 20, 1, 1,  1, 1, 0, 0};
        v[21] = '{0, 1, 20, 0, 1, 0,  0, 0, 0,  0, 1, 0, 0};
        v[22] = '{1, 1, 20, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0};
        v[23] = '{0, 0, 20, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            int ctrl;
            ctrl = 32'h15A5A ^ i;
            @(negedge clk);
            drive(v[i].rst, v[i].busy, v[i].rs, v[i].rt, v[i].urs, v[i].urt,
                  v[i].dst, v[i].wen, v[i].ld, ctrl);
            #1;
            chk($sformatf("s%0d pc_le", i),   32'(pc_le),     v[i].e_pc);
            chk($sformatf("s%0d ifid_le", i), 32'(ifid_le),   v[i].e_pc);
            chk($sformatf("s%0d ex_ctrl", i), 32'(ex_ctrl),   v[i].e_pc != 0 ? ctrl : 0);
            chk($sformatf("s%0d fwd_a", i),   32'(fwd_a),     v[i].e_fa);
            chk($sformatf("s%0d fwd_b", i),   32'(fwd_b),     v[i].e_fb);
            chk($sformatf("s%0d stall_cnt", i), 32'(stall_cnt), v[i].e_cnt);
            chk($sformatf("s%0d sat_cnt", i), 32'(s_cnt),     v[i].e_cnt > 3 ? 3 : v[i].e_cnt);
            if (i == 19)
                chk("state after reset in bubble", 32'(u_dut.r_state), 32'(RUN));
        end

        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 8, 1, 1, 32'h3);
            #1 chk($sformatf("sat%0d load pc_le", k), 32'(pc_le), 1);
            @(negedge clk);
            drive(0, 0, 8, 0, 1, 0, 0, 0, 0, 32'h7);
            #1 chk($sformatf("sat%0d use pc_le", k), 32'(pc_le), 0);
            chk($sformatf("sat%0d use sat pc_le", k), 32'(s_pc_le), 0);
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h9);
            #1 chk($sformatf("sat%0d bubble fwd_a", k), 32'(fwd_a), 0);
            chk($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), k);
            chk($sformatf("sat%0d sat_cnt", k), 32'(s_cnt), k > 3 ? 3 : k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
